// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a single registered valid/ready output stage.
// Optional error counter output err_cnt is enabled by defining IMM_GEN_ERR_CNT_EN.
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int TAG_W    = 4,
   parameter int AUTO_DEC = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      ins,
   input  logic [2:0]       sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
`ifdef IMM_GEN_ERR_CNT_EN
   ,
   output logic [15:0]      err_cnt
`endif
);

   typedef enum logic [2:0] {
      FMT_I     = 3'd0,
      FMT_S     = 3'd1,
      FMT_B     = 3'd2,
      FMT_U     = 3'd3,
      FMT_J     = 3'd4,
      FMT_SHAMT = 3'd5,
      FMT_ZIMM  = 3'd6,
      FMT_RSV   = 3'd7
   } fmt_e;

   fmt_e            auto_fmt;
   fmt_e            fmt;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_d, imm_q;
   logic            err_d, err_q;
   logic            valid_q;
   logic [TAG_W-1:0] tag_q;
   logic            in_fire;
   logic            out_fire;

   assign opcode = ins[6:0];
   assign funct3 = ins[14:12];

   always_comb begin
      auto_fmt = FMT_RSV;
      case (opcode)
         7'b0000011, 7'b1100111: auto_fmt = FMT_I;
         7'b0010011: auto_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
         7'b0100011: auto_fmt = FMT_S;
         7'b1100011: auto_fmt = FMT_B;
         7'b0110111, 7'b0010111: auto_fmt = FMT_U;
         7'b1101111: auto_fmt = FMT_J;
         7'b1110011: auto_fmt = funct3[2] ? FMT_ZIMM : FMT_I;
         default:    auto_fmt = FMT_RSV;
      endcase
   end

   assign fmt = (AUTO_DEC != 0) ? auto_fmt : fmt_e'(sel);

   // Signed sources are size-cast so they sign-extend to XLEN; zero-extended fields stay unsigned.
   always_comb begin
      imm_d = '0;
      err_d = 1'b0;
      case (fmt)
         FMT_I:     imm_d = XLEN'($signed(ins[31:20]));
         FMT_S:     imm_d = XLEN'($signed({ins[31:25], ins[11:7]}));
         FMT_B:     imm_d = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         FMT_U:     imm_d = XLEN'($signed({ins[31:12], 12'h000}));
         FMT_J:     imm_d = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         FMT_SHAMT: imm_d = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
         FMT_ZIMM:  imm_d = XLEN'(ins[19:15]);
         default:   err_d = 1'b1;
      endcase
   end

   // Handshake: a beat moves when valid && ready on the same rising edge. The output
   // register can take a new beat whenever it is empty or being drained this cycle;
   // the output side holds imm/out_tag/out_err/out_valid steady until out_ready.
   assign in_ready = !rst_n || !valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         imm_q   <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
      end else if (in_fire) begin
         valid_q <= 1'b1;
         imm_q   <= imm_d;
         tag_q   <= in_tag;
         err_q   <= err_d;
      end else if (out_fire) begin
         valid_q <= 1'b0;
      end
   end

`ifdef IMM_GEN_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (in_fire && err_d && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   assign out_valid = valid_q;
   assign imm       = imm_q;
   assign out_tag   = tag_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit sel-driven instance and a 64-bit auto-decode instance.
module tb_imm_gen_pipe;

   localparam int EW = 69;  // {err, tag[3:0], imm[63:0]}

   logic clk, rst_n;

   logic        in_valid32, in_ready32, out_valid32, ready32, out_err32;
   logic [31:0] ins32, imm32;
   logic [2:0]  sel32;
   logic [3:0]  tag32, out_tag32;

   logic        in_valid64, in_ready64, out_valid64, ready64, out_err64;
   logic [31:0] ins64;
   logic [63:0] imm64;
   logic [2:0]  sel64;
   logic [3:0]  tag64, out_tag64;

`ifdef IMM_GEN_ERR_CNT_EN
   logic [15:0] err_cnt32, err_cnt64;
`endif

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp64_q[$];
   int n_checks, n_fail, pops32, pops64;

   imm_gen_pipe #(.XLEN(32), .TAG_W(4), .AUTO_DEC(0)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .ins(ins32), .sel(sel32), .in_tag(tag32), .out_valid(out_valid32),
      .out_ready(ready32), .imm(imm32), .out_tag(out_tag32), .out_err(out_err32)
`ifdef IMM_GEN_ERR_CNT_EN
      , .err_cnt(err_cnt32)
`endif
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(4), .AUTO_DEC(1)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
      .ins(ins64), .sel(sel64), .in_tag(tag64), .out_valid(out_valid64),
      .out_ready(ready64), .imm(imm64), .out_tag(out_tag64), .out_err(out_err64)
`ifdef IMM_GEN_ERR_CNT_EN
      , .err_cnt(err_cnt64)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish checks=%0d", n_checks);
      $fatal(1);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference immediate, built from explicit bit concatenations in 64 bits.
   function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] f, input bit x64);
      logic s;
      s = i[31];
      case (f)
         3'd0: return {{52{s}}, i[31:20]};
         3'd1: return {{52{s}}, i[31:25], i[11:7]};
         3'd2: return {{51{s}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3: return {{32{s}}, i[31:12], 12'h000};
         3'd4: return {{43{s}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd5: return x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
         3'd6: return {59'd0, i[19:15]};
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [2:0] model_fmt(input logic [31:0] i);
      logic [6:0] op;
      logic [2:0] f3;
      op = i[6:0];
      f3 = i[14:12];
      if (op == 7'h03 || op == 7'h67) return 3'd0;
      if (op == 7'h13) return (f3[1:0] == 2'b01) ? 3'd5 : 3'd0;
      if (op == 7'h23) return 3'd1;
      if (op == 7'h63) return 3'd2;
      if (op == 7'h37 || op == 7'h17) return 3'd3;
      if (op == 7'h6F) return 3'd4;
      if (op == 7'h73) return f3[2] ? 3'd6 : 3'd0;
      return 3'd7;
   endfunction

   // ---------------- driver ----------------
   task automatic send(input bit wide, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [3:0] tag, input logic [63:0] e_imm, input bit e_err);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      if (wide) begin
         in_valid64 = 1'b1; ins64 = ins; sel64 = sel; tag64 = tag;
      end else begin
         in_valid32 = 1'b1; ins32 = ins; sel32 = sel; tag32 = tag;
      end
      while (!done && n < 200) begin
         @(negedge clk);
         done = wide ? in_ready64 : in_ready32;
         @(posedge clk); #1;
         n++;
      end
      if (!done) check(wide ? "in_timeout64" : "in_timeout32", 64'd0, 64'd1);
      else if (wide) exp64_q.push_back({e_err, tag, e_imm});
      else exp_q.push_back({e_err, tag, e_imm});
      if (wide) in_valid64 = 1'b0;
      else in_valid32 = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      exp_q.delete();
      exp64_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp64_q.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0 || exp64_q.size() != 0)
         check("drain_timeout", 64'(exp_q.size() + exp64_q.size()), 64'd0);
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n && out_valid32 && ready32) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out32", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("imm32", {32'd0, imm32}, e[63:0]);
            check("tag32", 64'(out_tag32), 64'(e[67:64]));
            check("err32", 64'(out_err32), 64'(e[68]));
            pops32++;
         end
      end
   end

   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n && out_valid64 && ready64) begin
         if (exp64_q.size() == 0) begin
            check("unexpected_out64", 64'd1, 64'd0);
         end else begin
            e = exp64_q.pop_front();
            check("imm64", imm64, e[63:0]);
            check("tag64", 64'(out_tag64), 64'(e[67:64]));
            check("err64", 64'(out_err64), 64'(e[68]));
            pops64++;
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [6:0] ops [10] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
   bit rnd_done;

   initial begin
      int p;
      int n;
      logic [31:0] ri;
      logic [2:0]  rs;
      logic [63:0] rm;

      n_checks = 0; n_fail = 0; pops32 = 0; pops64 = 0;
      rst_n = 1'b0;
      in_valid32 = 1'b0; ins32 = '0; sel32 = '0; tag32 = '0; ready32 = 1'b1;
      in_valid64 = 1'b0; ins64 = '0; sel64 = '0; tag64 = '0; ready64 = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("rst_out_valid", 64'(out_valid32), 64'd0);
      check("rst_imm", {32'd0, imm32}, 64'd0);
      check("rst_tag", 64'(out_tag32), 64'd0);
      check("rst_err", 64'(out_err32), 64'd0);
      check("rst_in_ready", 64'(in_ready32), 64'd1);
      check("rst_imm64", imm64, 64'd0);
      rst_n = 1'b1;

      // Directed formats on the 32-bit sel-driven instance
      send(0, 32'h00400113, 3'd0, 4'd1, 64'h4, 1'b0);
      check("latency_valid", 64'(out_valid32), 64'd1);
      send(0, 32'hFFF00093, 3'd0, 4'd2, 64'hFFFFFFFF, 1'b0);
      send(0, 32'hFE000EE3, 3'd2, 4'd3, 64'hFFFFFFFC, 1'b0);
      send(0, 32'h123456B7, 3'd3, 4'd4, 64'h12345000, 1'b0);
      send(0, 32'h001000EF, 3'd4, 4'd5, 64'h800, 1'b0);
      send(0, 32'hFE112E23, 3'd1, 4'd6, 64'hFFFFFFFC, 1'b0);
      send(0, 32'h0002D073, 3'd6, 4'd7, 64'h5, 1'b0);
      send(0, 32'h00400113, 3'd7, 4'd8, 64'h0, 1'b1);
      send(0, 32'h03F29293, 3'd5, 4'd9, 64'h1F, 1'b0);
      wait_drain();
      check("idle_valid_clear", 64'(out_valid32), 64'd0);
      check("idle_imm_hold", {32'd0, imm32}, 64'h1F);
      check("idle_tag_hold", 64'(out_tag32), 64'd9);

      // Backpressure: first result held for 3 cycles while three more wait
      p = pops32;
      ready32 = 1'b0;
      fork
         begin
            send(0, 32'h00400113, 3'd0, 4'hA, 64'h4, 1'b0);
            send(0, 32'hFFF00093, 3'd0, 4'hB, 64'hFFFFFFFF, 1'b0);
            send(0, 32'h123456B7, 3'd3, 4'hC, 64'h12345000, 1'b0);
            send(0, 32'h001000EF, 3'd4, 4'hD, 64'h800, 1'b0);
         end
         begin
            n = 0;
            while (!out_valid32 && n < 50) begin @(posedge clk); #1; n++; end
            repeat (3) begin
               check("bp_in_ready", 64'(in_ready32), 64'd0);
               check("bp_valid", 64'(out_valid32), 64'd1);
               check("bp_imm", {32'd0, imm32}, 64'h4);
               check("bp_tag", 64'(out_tag32), 64'hA);
               @(posedge clk); #1;
            end
            ready32 = 1'b1;
         end
      join
      wait_drain();
      check("bp_count", 64'(pops32 - p), 64'd4);

      // Reserved format and error counting
      do_reset();
      for (int i = 0; i < 3; i++)
         send(0, 32'h00400113, 3'd7, 4'(i + 1), 64'h0, 1'b1);
      wait_drain();
`ifdef IMM_GEN_ERR_CNT_EN
      check("err_cnt_3", 64'(err_cnt32), 64'd3);
      do_reset();
      check("err_cnt_rst", 64'(err_cnt32), 64'd0);
`endif

      // Reset while a result is stalled
      ready32 = 1'b0;
      send(0, 32'h00400113, 3'd0, 4'd7, 64'h4, 1'b0);
      check("pend_valid", 64'(out_valid32), 64'd1);
      check("pend_in_ready", 64'(in_ready32), 64'd0);
      rst_n = 1'b0;
      #1;
      check("rst_in_ready_pend", 64'(in_ready32), 64'd1);
      @(posedge clk); #1;
      exp_q.delete();
      check("rst_pend_valid", 64'(out_valid32), 64'd0);
      check("rst_pend_imm", {32'd0, imm32}, 64'd0);
      check("rst_pend_in_ready", 64'(in_ready32), 64'd1);
      rst_n = 1'b1;
      ready32 = 1'b1;

      // Random stream with random backpressure on the 32-bit instance
      rnd_done = 1'b0;
      fork
         begin
            logic [31:0] a_ins;
            logic [2:0]  a_sel;
            logic [63:0] a_m;
            for (int i = 0; i < 40; i++) begin
               a_ins = $urandom;
               a_sel = 3'($urandom_range(0, 7));
               a_m = model_imm(a_ins, a_sel, 1'b0);
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               send(0, a_ins, a_sel, 4'(i), {32'd0, a_m[31:0]}, a_sel == 3'd7);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               ready32 = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            ready32 = 1'b1;
         end
      join
      wait_drain();

      // 64-bit auto-decode instance: directed then random opcodes
      send(1, 32'h800002B7, 3'd7, 4'd1, 64'hFFFFFFFF80000000, 1'b0);
      send(1, 32'h03F29293, 3'd7, 4'd2, 64'h3F, 1'b0);
      send(1, 32'h0000007F, 3'd0, 4'd3, 64'h0, 1'b1);
      send(1, 32'h0002D073, 3'd0, 4'd4, 64'h5, 1'b0);
      send(1, 32'hFE000EE3, 3'd0, 4'd5, 64'hFFFFFFFFFFFFFFFC, 1'b0);
      for (int i = 0; i < 30; i++) begin
         ri = $urandom;
         ri[6:0] = ops[$urandom_range(0, 9)];
         rs = model_fmt(ri);
         rm = model_imm(ri, rs, 1'b1);
         send(1, ri, 3'($urandom_range(0, 7)), 4'(i), rm, rs == 3'd7);
      end
      wait_drain();
      check("pops64_total", 64'(pops64), 64'd35);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, output immediate width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried alongside each instruction.
REQ-003 Parameter AUTO_DEC, default 0; 0 = format taken from sel, 1 = format derived from ins opcode/funct3 and sel ignored.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  ins/sel/in_tag valid this cycle.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 ins  in  32  instruction word.
REQ-009 sel  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 ZIMM, 111 reserved.
REQ-010 in_tag  in  TAG_W  opaque tag, returned unchanged.
REQ-011 out_valid  out  1  registered result valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 imm  out  XLEN  generated immediate.
REQ-014 out_tag  out  TAG_W  tag of the instruction producing imm.
REQ-015 out_err  out  1  reserved/undecodable format flag, qualified by out_valid.

Function
REQ-016 I = sext(ins[31:20]); S = sext({ins[31:25],ins[11:7]}); B = sext({ins[31],ins[7],ins[30:25],ins[11:8],0}); J = sext({ins[31],ins[19:12],ins[20],ins[30:21],0}); sext to XLEN.
REQ-017 U = sext({ins[31:12],12'h000}) to XLEN (bits above 31 copy ins[31] when XLEN=64).
REQ-018 SHAMT = zero-extended ins[24:20] for XLEN=32, ins[25:20] for XLEN=64.
REQ-019 ZIMM = zero-extended ins[19:15].
REQ-020 Format 111 (or undecodable opcode in AUTO_DEC=1) yields imm=0, out_err=1; all other formats out_err=0.
REQ-021 AUTO_DEC=1 map: 0000011/1100111 I; 0010011 I except funct3 001/101 SHAMT; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; 1110011 ZIMM if funct3[2]=1, I otherwise; all else reserved.
REQ-022 Single output register stage; latency exactly one cycle from accepted input to out_valid.
REQ-023 in_ready = !out_valid || out_ready (combinational); full throughput of one per cycle under no backpressure.
REQ-024 Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-025 Simultaneous in/out transfer in one cycle: register reloads with new result, out_valid stays 1.
REQ-026 Out transfer without in transfer: out_valid clears next cycle.
REQ-027 out_valid=1 && out_ready=0: imm, out_tag, out_err, out_valid held stable until accepted.
REQ-028 in_valid=0 with empty register: out_valid stays 0; imm/out_tag hold previous value.

Reset
REQ-029 rst_n=0 sampled at rising clk: out_valid=0, imm=0, out_tag=0, out_err=0 next cycle; in_ready=1 during reset.
REQ-030 Reset asserted with a result pending discards it; no transfer completes in the reset cycle.

Configuration
REQ-031 Macro IMM_GEN_ERR_CNT_EN defined: extra output err_cnt (16 bits) counts accepted inputs producing out_err=1, saturates at 0xFFFF, cleared by reset.
REQ-032 Macro undefined: no err_cnt port or counter logic; all other behaviour identical.

Verification
REQ-033 XLEN=32, sel=000, ins=0x00400113 -> one cycle later out_valid=1, imm=0x00000004; ins=0xFFF00093 -> imm=0xFFFFFFFF.
REQ-034 sel=010, ins=0xFE000EE3 -> imm=0xFFFFFFFC; sel=011, ins=0x123456B7 -> imm=0x12345000; sel=100, ins=0x001000EF -> imm=0x00000800.
REQ-035 XLEN=64, AUTO_DEC=1, ins=0x800002B7 -> imm=0xFFFFFFFF80000000; ins=0x03F29293 (slli) -> imm=0x000000000000003F.
REQ-036 Backpressure: stream 4 tagged inputs, hold out_ready=0 for 3 cycles after first result -> in_ready=0, outputs stable, all 4 tags emerge in order, none lost or duplicated.
REQ-037 sel=111 with ins=0x00400113 -> imm=0, out_err=1; with IMM_GEN_ERR_CNT_EN, 3 such inputs -> err_cnt=3, reset -> err_cnt=0.
REQ-038 rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, imm=0, in_ready=1.
